zuart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one ZUART transmitter among NREQ byte producers (snapshot

---
 rtl/zuart_pkg.sv | 29 ++
 rtl/zuart_tx_sched_if.sv | 35 +++
 rtl/zrr_arbiter.sv | 46 ++++
 rtl/zuart_tx_sched.sv | 147 ++++++++++++++
 tb/tb_zuart_tx_sched.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zuart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zuart_pkg                                                        |
// | Shared types and constants for the ZUART transmit scheduler.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package zuart_pkg;

  localparam int OWNER_W = 3;   // width of a requester index (up to 8 requesters)
  localparam int TMO_W   = 16;  // width of the timeout and gap counters

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Round-robin successor of the given owner, wrapping at nreq.
  function automatic logic [OWNER_W-1:0] next_ptr(input logic [OWNER_W-1:0] owner,
                                                  input int nreq);
    if (int'(owner) >= nreq - 1) begin
      return '0;
    end
    return owner + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zuart_tx_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zuart_tx_sched_if                                                |
// | Requester and transmitter signals around the TX scheduler.       |
// | master: the scheduler; slave: requesters plus transmitter.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface zuart_tx_sched_if
  import zuart_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]    iReq;
  logic [8*NREQ-1:0]  iData;
  logic [NREQ-1:0]    oAck;
  logic [NREQ-1:0]    oErr;
  logic               oTxEn;
  logic [7:0]         oTxData;
  logic               iTxDone;
  logic               oBusy;
  logic [OWNER_W-1:0] oOwner;

  modport master (
    input  iReq, iData, iTxDone,
    output oAck, oErr, oTxEn, oTxData, oBusy, oOwner
  );

  modport slave (
    output iReq, iData, iTxDone,
    input  oAck, oErr, oTxEn, oTxData, oBusy, oOwner
  );

endinterface
`default_nettype wire

// File: rtl/zrr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zrr_arbiter                                                      |
// | Combinational round-robin pick: first set request at or after    |
// | the pointer, wrapping around to the lowest index.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module zrr_arbiter
  import zuart_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [OWNER_W-1:0] idx,
  output logic               valid
);

  logic [OWNER_W-1:0] w_pick_hi;
  logic [OWNER_W-1:0] w_pick_lo;
  logic               w_found_hi;
  logic               w_found_lo;

  // Lowest set request at/after the pointer, else lowest set request overall.
  always_comb begin
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    // Scan downwards so the last hit written is the lowest index.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (|(req & (NREQ'(1) << k))) begin
        w_pick_lo  = OWNER_W'(k);
        w_found_lo = 1'b1;
        if (k >= int'(ptr)) begin
          w_pick_hi  = OWNER_W'(k);
          w_found_hi = 1'b1;
        end
      end
    end
    idx   = w_found_hi ? w_pick_hi : w_pick_lo;
    valid = w_found_lo;
  end

endmodule
`default_nettype wire

// File: rtl/zuart_tx_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | zuart_tx_sched                                                   |
// | Round-robin scheduler sharing one ZUART transmitter among NREQ   |
// | byte producers, with inter-byte gap and hung-transfer timeout.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module zuart_tx_sched
  import zuart_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic             iClk,
  input  logic             iRst_N,
  zuart_tx_sched_if.master bus
);

  state_t             r_state;
  state_t             w_next;
  logic [OWNER_W-1:0] r_ptr;
  logic [OWNER_W-1:0] r_owner;
  logic [7:0]         r_tx_data;
  logic [TMO_W-1:0]   r_tmo;
  logic [TMO_W-1:0]   r_gap;
  logic [NREQ-1:0]    r_ack;
  logic [NREQ-1:0]    r_err;

  logic [OWNER_W-1:0] w_pick;
  logic               w_pick_vld;
  logic               w_done;
  logic               w_expire;
  logic               w_gap_end;
  logic               w_tx_en;
  logic               w_busy;
  logic [7:0]         w_bytes [2**OWNER_W];

  // Unpack the byte bus into an array indexable by a full owner index;
  // slots beyond NREQ read as zero and can never be granted.
  generate
    for (genvar g = 0; g < 2**OWNER_W; g++) begin : g_bytes
      if (g < NREQ) begin : g_used
        assign w_bytes[g] = bus.iData[8*g +: 8];
      end else begin : g_unused
        assign w_bytes[g] = 8'h00;
      end
    end
  endgenerate

  zrr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (bus.iReq),
    .ptr   (r_ptr),
    .idx   (w_pick),
    .valid (w_pick_vld)
  );

  assign w_done    = bus.iTxDone;
  assign w_expire  = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_gap_end = (r_gap == TMO_W'(GAP_CYC - 1));

  // State register; reset drops straight back to IDLE, killing oTxEn.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: done wins over expiry since both leave SEND the same way.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|bus.iReq) w_next = S_ARB;
      S_ARB:   w_next = w_pick_vld ? S_SEND : S_IDLE;
      S_SEND:  if (w_done || w_expire) w_next = S_GAP;
      S_GAP:   if (w_gap_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state: enable only while sending, busy outside IDLE.
  always_comb begin
    w_tx_en = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE:  w_busy  = 1'b0;
      S_SEND:  w_tx_en = 1'b1;
      default: ;
    endcase
  end

  // Grant latch, timeout/gap counters, pointer advance and result pulses.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_tx_data <= '0;
      r_tmo     <= '0;
      r_gap     <= '0;
      r_ack     <= '0;
      r_err     <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        S_ARB: begin
          if (w_pick_vld) begin
            r_owner   <= w_pick;
            r_tx_data <= w_bytes[w_pick];
            r_tmo     <= '0;
          end
        end
        S_SEND: begin
          if (r_tmo != '1) begin
            r_tmo <= r_tmo + 1'b1;
          end
          if (w_done) begin
            r_ack <= NREQ'(1) << r_owner;
          end else if (w_expire) begin
            r_err <= NREQ'(1) << r_owner;
          end
          if (w_done || w_expire) begin
            r_ptr <= next_ptr(r_owner, NREQ);
            r_gap <= '0;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.oTxEn   = w_tx_en;
  assign bus.oBusy   = w_busy;
  assign bus.oTxData = r_tx_data;
  assign bus.oOwner  = r_owner;
  assign bus.oAck    = r_ack;
  assign bus.oErr    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_zuart_tx_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_zuart_tx_sched                                                |
// | Scoreboard bench: driver pushes predicted grants/results, a      |
// | monitor pops and compares on every grant and every ack/err.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_zuart_tx_sched;
  import zuart_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TMO = 320;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zuart_tx_sched_if #(.NREQ(N)) bus ();

  zuart_tx_sched #(
    .NREQ        (N),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .iClk   (clk),
    .iRst_N (rst_n),
    .bus    (bus)
  );

  logic [N-1:0] req;
  logic [7:0]   bytes [N];
  logic         done;

  assign bus.iReq    = req;
  assign bus.iData   = {bytes[3], bytes[2], bytes[1], bytes[0]};
  assign bus.iTxDone = done;

  typedef struct {
    bit         err;
    int         owner;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   ptr_m   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: scan requesters starting at the pointer, wrapping modulo N.
  function automatic int model_pick(input logic [N-1:0] m, input int p);
    for (int off = 0; off < N; off++) begin
      int c;
      c = (p + off) % N;
      if (((m >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  // Monitor: checks each grant and each ack/err pulse against the queue head.
  logic         prev_en;
  int           low_run;
  exp_t         e;
  logic [N-1:0] oh;
  initial begin
    prev_en = 1'b0;
    low_run = 1000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
        low_run = 1000;
      end else begin
        if (bus.oTxEn && !prev_en) begin
          chk("gap_before_grant", 32'(low_run >= GAP), 32'd1);
          if (q.size() == 0) begin
            chk("unexpected_grant", 32'd0, 32'd1);
          end else begin
            chk("grant_owner", 32'(bus.oOwner), 32'(q[0].owner));
            chk("grant_data", 32'(bus.oTxData), 32'(q[0].data));
          end
        end
        if (|bus.oAck || |bus.oErr) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'd0, 32'd1);
          end else begin
            e  = q.pop_front();
            oh = N'(1) << e.owner;
            chk("ack_vec", 32'(bus.oAck), e.err ? 32'd0 : 32'(oh));
            chk("err_vec", 32'(bus.oErr), e.err ? 32'(oh) : 32'd0);
            chk("txen_low_at_result", 32'(bus.oTxEn), 32'd0);
          end
        end
        if (bus.oTxEn) low_run = 0;
        else if (low_run < 1000) low_run++;
        prev_en = bus.oTxEn;
      end
    end
  end

  // One transfer: raise requests, predict winner, serve it as the transmitter.
  // dly<0 means never assert iTxDone; otherwise done in SEND cycle index dly.
  task automatic do_txn(input logic [N-1:0] add, input int dly, input bit chk_lat,
                        output int own);
    int         w;
    int         waited;
    int         high;
    int         exp_high;
    logic [1:0] kk;
    own = -1;
    for (int k = 0; k < N; k++) begin
      kk = 2'(k);
      if (((add >> k) & N'(1)) != '0 && ((req >> k) & N'(1)) == '0) begin
        bytes[kk] = 8'($urandom);
        req       = req | (N'(1) << k);
      end
    end
    if (req == '0) begin
      @(negedge clk);
      return;
    end
    w = model_pick(req, ptr_m);
    q.push_back('{err: !(dly >= 0 && dly < TMO), owner: w, data: bytes[2'(w)]});
    waited = 0;
    while (!bus.oTxEn && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.oTxEn) begin
      chk("grant_wait_expired", 32'd0, 32'd1);
      q.delete();
      req = '0;
      return;
    end
    own = int'(bus.oOwner);
    if (chk_lat) chk("req_to_txen_latency", 32'(waited), 32'd2);
    high = 0;
    while (bus.oTxEn && high < TMO + 8) begin
      if (high == dly) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      high++;
    end
    exp_high = (dly >= 0 && dly < TMO) ? dly + 1 : TMO;
    chk("txen_high_cycles", 32'(high), 32'(exp_high));
    // Now in the result-pulse cycle; withdraw on the following cycle.
    @(negedge clk);
    req   = req & ~(N'(1) << w);
    ptr_m = (w + 1) % N;
    @(negedge clk);
  endtask

  int   own;
  int   dly;
  int   r;
  logic seen;

  initial begin
    req   = '0;
    done  = 1'b0;
    for (int k = 0; k < N; k++) bytes[2'(k)] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txen", 32'(bus.oTxEn), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_ack", 32'(bus.oAck), 32'd0);
    chk("rst_err", 32'(bus.oErr), 32'd0);
    chk("rst_owner", 32'(bus.oOwner), 32'd0);
    chk("rst_txdata", 32'(bus.oTxData), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Rotation with every requester held and re-raised after its ack.
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, int'($urandom_range(0, 6)), 1'b0, own);
      chk("rotation_order", 32'(own), 32'(i % N));
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Single requester, long transfer, fixed byte.
    bytes[1] = 8'hA5;
    req      = 4'b0010;
    do_txn('0, 300, 1'b1, own);
    chk("single_owner", 32'(own), 32'd1);
    chk("single_txdata", 32'(bus.oTxData), 32'hA5);

    // Timeout with no done, then back to idle.
    do_txn(4'b0001, -1, 1'b1, own);
    @(negedge clk);
    chk("idle_after_timeout", 32'(bus.oBusy), 32'd0);

    // Done in the same cycle the count expires.
    do_txn(4'b0100, TMO - 1, 1'b1, own);

    // Withdrawn request, plus a stray done while idle.
    @(negedge clk);
    chk("withdraw_idle", 32'(bus.oBusy), 32'd0);
    bytes[3] = 8'($urandom);
    req      = 4'b1000;
    @(negedge clk);
    chk("withdraw_arb_busy", 32'(bus.oBusy), 32'd1);
    req = '0;
    @(negedge clk);
    chk("withdraw_back_idle", 32'(bus.oBusy), 32'd0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | bus.oTxEn | bus.oBusy;
    end
    chk("withdraw_no_activity", 32'(seen), 32'd0);

    // Reset in the middle of a transfer.
    do_txn(4'b0001, 3, 1'b0, own);
    bytes[0] = 8'($urandom);
    bytes[2] = 8'($urandom);
    req      = 4'b0101;
    q.push_back('{err: 1'b0, owner: model_pick(req, ptr_m), data: bytes[2'(model_pick(req, ptr_m))]});
    r = 0;
    while (!bus.oTxEn && r < 12) begin
      @(negedge clk);
      r++;
    end
    chk("pre_reset_grant", 32'(bus.oTxEn), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_txen_drop", 32'(bus.oTxEn), 32'd0);
    chk("reset_busy_drop", 32'(bus.oBusy), 32'd0);
    chk("reset_owner", 32'(bus.oOwner), 32'd0);
    q.delete();
    ptr_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn('0, 4, 1'b0, own);
    chk("post_reset_lowest", 32'(own), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      dly = -1;
      else if (r == 1) dly = TMO - 1;
      else             dly = int'($urandom_range(0, 30));
      do_txn(N'($urandom), dly, 1'b0, own);
    end
    req = '0;
    repeat (8) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_idle", 32'(bus.oBusy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
